// File: rtl/debounce_edge_detect.sv
// Switch conditioner: synchronizer, stability-count debounce FSM, edge pulses and bounce reporting.
// Optional auto-repeat of rise_pulse while held, enabled by defining DEBOUNCE_AUTOREPEAT_EN.
module debounce_edge_detect #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY  = 64,
  parameter int unsigned REPEAT_PERIOD = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  input  logic en,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic glitch
);

  typedef enum logic [1:0] {
    IDLE_LOW,
    WAIT_HIGH,
    IDLE_HIGH,
    WAIT_LOW
  } state_t;

  // Acceptance fires on the last counted sample, so the counter never reaches STABLE_CYCLES.
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("debounce_edge_detect: SYNC_STAGES must be at least 2");
  end
  if (STABLE_CYCLES < 1 || STABLE_CYCLES >= (1 << CNT_W)) begin : g_chk_stable
    $error("debounce_edge_detect: STABLE_CYCLES out of range for CNT_W");
  end
  if (REPEAT_DELAY < 1 || REPEAT_DELAY >= (1 << CNT_W)) begin : g_chk_delay
    $error("debounce_edge_detect: REPEAT_DELAY out of range for CNT_W");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_PERIOD >= (1 << CNT_W)) begin : g_chk_period
    $error("debounce_edge_detect: REPEAT_PERIOD out of range for CNT_W");
  end

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_in;
  state_t                 state;
  logic [CNT_W-1:0]       stab_cnt;

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rep_cnt;
  logic             rep_armed;
`endif

  // Metastability synchronizer, runs every clk regardless of en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  // Debounce FSM with registered level and single-cycle pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE_LOW;
      stab_cnt   <= '0;
      level      <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      glitch     <= 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
      rep_cnt    <= '0;
      rep_armed  <= 1'b0;
`endif
    end else begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      glitch     <= 1'b0;
      unique case (state)
        IDLE_LOW: begin
          if (sync_in) begin
            state    <= WAIT_HIGH;
            stab_cnt <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!sync_in) begin
            state  <= IDLE_LOW;
            glitch <= 1'b1;
          end else if (en) begin
            if (stab_cnt == STABLE_LAST) begin
              state      <= IDLE_HIGH;
              level      <= 1'b1;
              rise_pulse <= 1'b1;
`ifdef DEBOUNCE_AUTOREPEAT_EN
              rep_cnt    <= '0;
              rep_armed  <= 1'b0;
`endif
            end else begin
              stab_cnt <= stab_cnt + CNT_W'(1);
            end
          end
        end
        IDLE_HIGH: begin
          if (!sync_in) begin
            state    <= WAIT_LOW;
            stab_cnt <= '0;
          end
`ifdef DEBOUNCE_AUTOREPEAT_EN
          // First repeat after REPEAT_DELAY samples, then every REPEAT_PERIOD.
          else if (en) begin
            if (rep_cnt == (rep_armed ? PERIOD_LAST : DELAY_LAST)) begin
              rise_pulse <= 1'b1;
              rep_cnt    <= '0;
              rep_armed  <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + CNT_W'(1);
            end
          end
`endif
        end
        WAIT_LOW: begin
          if (sync_in) begin
            state  <= IDLE_HIGH;
            glitch <= 1'b1;
          end else if (en) begin
            if (stab_cnt == STABLE_LAST) begin
              state      <= IDLE_LOW;
              level      <= 1'b0;
              fall_pulse <= 1'b1;
`ifdef DEBOUNCE_AUTOREPEAT_EN
              rep_cnt    <= '0;
              rep_armed  <= 1'b0;
`endif
            end else begin
              stab_cnt <= stab_cnt + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debounce_edge_detect.sv
// Bench for debounce_edge_detect: table of btn steps with expected events, scoreboard queue
// checked every cycle, plus hand sequences for sample-enable, async reset and auto-repeat.
module tb_debounce_edge_detect;

  localparam logic [2:0] EV_NONE   = 3'b000;
  localparam logic [2:0] EV_RISE   = 3'b100;
  localparam logic [2:0] EV_FALL   = 3'b010;
  localparam logic [2:0] EV_GLITCH = 3'b001;

  typedef struct {
    logic        btn;
    int unsigned hold;
    logic [2:0]  ev;
    int unsigned delay;
  } vec_t;

  typedef struct {
    int unsigned edge_no;
    logic [2:0]  pulses;
    logic        lvl;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_in = 1'b0;
  logic en = 1'b1;
  logic level, rise_pulse, fall_pulse, glitch;

  int unsigned cyc = 0;
  int unsigned en_div = 1;
  int total = 0;
  int bad = 0;
  logic exp_level = 1'b0;
  logic plan_level = 1'b0;
  exp_t q[$];
  vec_t vecs[15];

  debounce_edge_detect #(
    .SYNC_STAGES  (2),
    .CNT_W        (8),
    .STABLE_CYCLES(4),
    .REPEAT_DELAY (8),
    .REPEAT_PERIOD(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .en        (en),
    .level     (level),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .glitch    (glitch)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at edge %0d: got %b want %b (level,rise,fall,glitch)", name, cyc, got, want);
    end
  endtask

  task automatic push_at(input int unsigned edge_no, input logic [2:0] ev);
    exp_t e;
    if (ev == EV_RISE) plan_level = 1'b1;
    else if (ev == EV_FALL) plan_level = 1'b0;
    e.edge_no = edge_no;
    e.pulses  = ev;
    e.lvl     = plan_level;
    q.push_back(e);
  endtask

  // One cycle: compare outputs of the edge just taken, then set en for the next edge.
  task automatic step(input string name);
    logic [2:0] exp_p;
    @(negedge clk);
    exp_p = EV_NONE;
    if (q.size() != 0 && q[0].edge_no == cyc) begin
      exp_p     = q[0].pulses;
      exp_level = q[0].lvl;
      void'(q.pop_front());
    end
    check(name, {level, rise_pulse, fall_pulse, glitch}, {exp_level, exp_p});
    en = ((cyc + 1) % en_div == 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned e;
    int unsigned n;
    int unsigned k;

    vecs[0]  = '{1'b0, 4,  EV_NONE,   0};
    vecs[1]  = '{1'b1, 3,  EV_NONE,   0};
    vecs[2]  = '{1'b0, 8,  EV_GLITCH, 3};
    vecs[3]  = '{1'b1, 1,  EV_NONE,   0};
    vecs[4]  = '{1'b0, 8,  EV_GLITCH, 3};
    vecs[5]  = '{1'b1, 2,  EV_NONE,   0};
    vecs[6]  = '{1'b0, 8,  EV_GLITCH, 3};
    vecs[7]  = '{1'b1, 7,  EV_RISE,   7};
    vecs[8]  = '{1'b0, 2,  EV_NONE,   0};
    vecs[9]  = '{1'b1, 4,  EV_GLITCH, 3};
    vecs[10] = '{1'b0, 12, EV_FALL,   7};
    vecs[11] = '{1'b1, 4,  EV_NONE,   0};
    vecs[12] = '{1'b0, 8,  EV_GLITCH, 3};
    vecs[13] = '{1'b1, 5,  EV_RISE,   7};
    vecs[14] = '{1'b0, 12, EV_FALL,   7};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_state", {level, rise_pulse, fall_pulse, glitch}, 4'b0000);
    reset = 1'b1;
    step("post_reset");

    // Table-driven btn steps: bounces of 1..4 clks, clean press/release, release bounce
    foreach (vecs[i]) begin
      btn_in = vecs[i].btn;
      if (vecs[i].ev != EV_NONE) push_at(cyc + vecs[i].delay, vecs[i].ev);
      repeat (vecs[i].hold) step($sformatf("vec%0d", i));
    end

    // Sample enable one clk in four: acceptance on the 4th enabled sample after WAIT entry
    en_div = 4;
    step("en_setup");
    btn_in = 1'b1;
    e = cyc + 3;
    n = 0;
    while (n < 4) begin
      e++;
      if (e % 4 == 0) n++;
    end
    push_at(e, EV_RISE);
    repeat (24) step("en_press");
    btn_in = 1'b0;
    e = cyc + 3;
    n = 0;
    while (n < 4) begin
      e++;
      if (e % 4 == 0) n++;
    end
    push_at(e, EV_FALL);
    repeat (24) step("en_release");
    en_div = 1;
    step("en_restore");

    // Async reset asserted between edges right after acceptance, btn held high through it
    btn_in = 1'b1;
    repeat (6) step("rst_press");
    @(posedge clk);
    #1;
    check("rst_accept", {level, rise_pulse, fall_pulse, glitch}, 4'b1100);
    reset = 1'b0;
    #1;
    check("rst_async_clear", {level, rise_pulse, fall_pulse, glitch}, 4'b0000);
    exp_level  = 1'b0;
    plan_level = 1'b0;
    q.delete();
    repeat (2) step("rst_hold");
    reset = 1'b1;
    push_at(cyc + 7, EV_RISE);
    repeat (10) step("rst_fresh_press");
    btn_in = 1'b0;
    push_at(cyc + 7, EV_FALL);
    repeat (12) step("rst_release");

    // Long hold: auto-repeat at +15 then every 4 when enabled, single pulse otherwise
    k = cyc;
    btn_in = 1'b1;
    push_at(k + 7, EV_RISE);
`ifdef DEBOUNCE_AUTOREPEAT_EN
    for (int r = 15; r <= 39; r += 4) push_at(k + r, EV_RISE);
`endif
    push_at(k + 45, EV_FALL);
    repeat (38) step("hold_press");
    btn_in = 1'b0;
    repeat (16) step("hold_release");

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
